// File: rtl/vga_nios_mul_pkg.sv
// vga_nios_mul_pkg: op encodings, sequencer states and cell latency limits for the multiply path
package vga_nios_mul_pkg;
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;
  typedef enum logic [2:0] {IDLE, P1, W1, P2, W2, RESP} state_e;
  localparam int CELL_LATENCY_DEF = 1;
  localparam int CELL_LATENCY_MIN = 1;
  localparam int CELL_LATENCY_MAX = 4;
endpackage

// File: rtl/vga_nios_cpu_mult_seq_if.sv
// vga_nios_cpu_mult_seq_if: request, response and multiply-cell signals of the sequencer
interface vga_nios_cpu_mult_seq_if;
  logic req_valid, req_ready;
  logic [1:0] req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] cell_src1, cell_src2;
  logic cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;
  logic rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
    input  req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, cell_p1, cell_p2, cell_p3,
    output req_ready, rsp_valid, rsp_data, cell_src1, cell_src2, cell_en
  );
endinterface

// File: rtl/vga_nios_mul_combine.sv
// vga_nios_mul_combine: folds partial products into the low word or the sign-corrected high word
module vga_nios_mul_combine
  import vga_nios_mul_pkg::*;
(
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  input  logic [31:0] hh,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  op_e         op,
  output logic [31:0] result
);
  logic [32:0] mid;
  logic [63:0] full;
  logic [31:0] corr;
  always_comb begin
    mid = {1'b0, p2} + {1'b0, p3};
    full = {32'h0, p1} + {15'h0, mid, 16'h0} + {hh, 32'h0};
    // unsigned high word minus the two's-complement weight of each signed operand
    corr = ((op inside {OP_MULXSU, OP_MULXSS}) && a[31] ? b : 32'h0)
         + (op == OP_MULXSS && b[31] ? a : 32'h0);
    result = op == OP_MUL ? full[31:0] : full[63:32] - corr;
  end
endmodule

// File: rtl/vga_nios_cpu_mult_seq.sv
// vga_nios_cpu_mult_seq: sequences one or two passes through the 16x16 multiply cell per request
module vga_nios_cpu_mult_seq
  import vga_nios_mul_pkg::*;
#(
  parameter int CELL_LATENCY = CELL_LATENCY_DEF
) (
  input logic clk,
  input logic reset,
  vga_nios_cpu_mult_seq_if.slave bus
);
  state_e state, next;
  op_e op;
  logic [31:0] a, b, p1, p2, p3, src1, src2, data, result;
  logic [1:0] cnt;
  logic done, accept;
  assign done = cnt == 2'(CELL_LATENCY - 1);
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.req_ready = state == IDLE && !reset;
  assign bus.cell_en = state == P1 || state == P2;
  assign bus.cell_src1 = src1;
  assign bus.cell_src2 = src2;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_data = data;
  // live cell outputs are used in the capture cycle so the result registers on entry to RESP
  vga_nios_mul_combine u_combine (
    .p1(state == W1 ? bus.cell_p1 : p1),
    .p2(state == W1 ? bus.cell_p2 : p2),
    .p3(state == W1 ? bus.cell_p3 : p3),
    .hh(bus.cell_p1),
    .a(a),
    .b(b),
    .op(op),
    .result(result)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = accept ? P1 : IDLE;
      P1:   next = W1;
      W1:   next = !done ? W1 : op == OP_MUL ? RESP : P2;
      P2:   next = W2;
      W2:   next = done ? RESP : W2;
      RESP: next = bus.rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      src1 <= '0;
      src2 <= '0;
      data <= '0;
      cnt <= '0;
    end else begin
      cnt <= (state == W1 || state == W2) ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        a <= bus.req_a;
        b <= bus.req_b;
        op <= op_e'(bus.req_op);
        src1 <= bus.req_a;
        src2 <= bus.req_b;
      end
      if (state == W1 && done) begin
        p1 <= bus.cell_p1;
        p2 <= bus.cell_p2;
        p3 <= bus.cell_p3;
        if (op != OP_MUL) begin
          src1 <= {16'h0, a[31:16]};
          src2 <= {16'h0, b[31:16]};
        end
      end
      if (next == RESP && state != RESP)
        data <= result;
    end
  end
endmodule

// File: tb/tb_vga_nios_cpu_mult_seq.sv
// tb_vga_nios_cpu_mult_seq: directed checks of the multiply sequencer with latency-1 and latency-3 cells
module tb_vga_nios_cpu_mult_seq;
  import vga_nios_mul_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  vga_nios_cpu_mult_seq_if b1 ();
  vga_nios_cpu_mult_seq_if b3 ();
  vga_nios_cpu_mult_seq #(.CELL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  vga_nios_cpu_mult_seq #(.CELL_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [95:0] prods(input logic [31:0] x, input logic [31:0] y);
    return {32'(x[15:0]) * 32'(y[15:0]), 32'(x[15:0]) * 32'(y[31:16]), 32'(x[31:16]) * 32'(y[15:0])};
  endfunction

  logic [95:0] c1, s0, s1, s2;
  always @(posedge clk) begin
    if (b1.cell_en) c1 <= prods(b1.cell_src1, b1.cell_src2);
    if (b3.cell_en) s0 <= prods(b3.cell_src1, b3.cell_src2);
    s1 <= s0;
    s2 <= s1;
  end
  assign {b1.cell_p1, b1.cell_p2, b1.cell_p3} = c1;
  assign {b3.cell_p1, b3.cell_p2, b3.cell_p3} = s2;

  task automatic issue1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    b1.req_valid = 1'b1;
    b1.req_op = op;
    b1.req_a = a;
    b1.req_b = b;
    @(negedge clk);
    b1.req_valid = 1'b0;
  endtask

  task automatic run1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat,
                      output logic early, output logic v, output logic [31:0] d);
    issue1(op, a, b);
    repeat (lat - 2) @(negedge clk);
    early = b1.rsp_valid;
    @(negedge clk);
    v = b1.rsp_valid;
    d = b1.rsp_data;
  endtask

  task automatic run3(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat,
                      output logic early, output logic v, output logic [31:0] d);
    b3.req_valid = 1'b1;
    b3.req_op = op;
    b3.req_a = a;
    b3.req_b = b;
    @(negedge clk);
    b3.req_valid = 1'b0;
    repeat (lat - 2) @(negedge clk);
    early = b3.rsp_valid;
    @(negedge clk);
    v = b3.rsp_valid;
    d = b3.rsp_data;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (b1.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got=%b want=0", b1.req_ready); end
    vectors++; if (b1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b want=0", b1.rsp_valid); end
    vectors++; if (b1.rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got=%h want=0", b1.rsp_data); end
    vectors++; if (b1.cell_en !== 1'b0) begin miscompares++; $display("FAIL reset_cell_en got=%b want=0", b1.cell_en); end
    vectors++; if ({b1.cell_src1, b1.cell_src2} !== 64'h0) begin miscompares++; $display("FAIL reset_cell_src got=%h/%h want=0/0", b1.cell_src1, b1.cell_src2); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (b1.req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready got=%b want=1", b1.req_ready); end
  endtask

  task automatic test_mul;
    b1.rsp_ready = 1'b1;
    issue1(OP_MUL, 32'h0001_0003, 32'h0002_0005);
    vectors++; if (b1.cell_en !== 1'b1) begin miscompares++; $display("FAIL mul_c1_cell_en got=%b want=1", b1.cell_en); end
    vectors++; if ({b1.cell_src1, b1.cell_src2} !== 64'h0001_0003_0002_0005) begin miscompares++; $display("FAIL mul_c1_src got=%h/%h want=00010003/00020005", b1.cell_src1, b1.cell_src2); end
    @(negedge clk);
    vectors++; if ({b1.cell_en, b1.rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL mul_c2_en_valid got=%b%b want=00", b1.cell_en, b1.rsp_valid); end
    @(negedge clk);
    vectors++; if ({b1.cell_en, b1.rsp_valid} !== 2'b01) begin miscompares++; $display("FAIL mul_c3_en_valid got=%b%b want=01", b1.cell_en, b1.rsp_valid); end
    vectors++; if (b1.rsp_data !== 32'h000B_000F) begin miscompares++; $display("FAIL mul_data got=%h want=000b000f", b1.rsp_data); end
    @(negedge clk);
    vectors++; if ({b1.req_ready, b1.rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL mul_c4_idle got=%b%b want=10", b1.req_ready, b1.rsp_valid); end
  endtask

  task automatic test_mulxuu;
    b1.rsp_ready = 1'b1;
    issue1(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    vectors++; if (b1.cell_en !== 1'b0) begin miscompares++; $display("FAIL xuu_w1_cell_en got=%b want=0", b1.cell_en); end
    @(negedge clk);
    vectors++; if (b1.cell_en !== 1'b1) begin miscompares++; $display("FAIL xuu_p2_cell_en got=%b want=1", b1.cell_en); end
    vectors++; if ({b1.cell_src1, b1.cell_src2} !== 64'h0000_FFFF_0000_FFFF) begin miscompares++; $display("FAIL xuu_p2_src got=%h/%h want=0000ffff/0000ffff", b1.cell_src1, b1.cell_src2); end
    @(negedge clk);
    vectors++; if (b1.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL xuu_c4_valid got=%b want=0", b1.rsp_valid); end
    @(negedge clk);
    vectors++; if ({b1.rsp_valid, b1.rsp_data} !== {1'b1, 32'hFFFF_FFFE}) begin miscompares++; $display("FAIL xuu_c5_rsp got=%b/%h want=1/fffffffe", b1.rsp_valid, b1.rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_signed;
    logic [1:0] ops [4] = '{2'b11, 2'b10, 2'b11, 2'b10};
    logic [31:0] as [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] bs [4] = '{32'h0000_0002, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'hC000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic early, v;
    logic [31:0] d;
    b1.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run1(ops[i], as[i], bs[i], 5, early, v, d);
      vectors++; if ({early, v} !== 2'b01) begin miscompares++; $display("FAIL signed%0d_timing got=%b%b want=01", i, early, v); end
      vectors++; if (d !== exp[i]) begin miscompares++; $display("FAIL signed%0d_data got=%h want=%h", i, d, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    logic early, v;
    logic [31:0] d;
    b1.rsp_ready = 1'b0;
    run1(OP_MUL, 32'd7, 32'd6, 3, early, v, d);
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({b1.rsp_valid, b1.rsp_data} !== {1'b1, 32'h0000_002A}) begin miscompares++; $display("FAIL bp%0d_rsp got=%b/%h want=1/0000002a", i, b1.rsp_valid, b1.rsp_data); end
      vectors++; if ({b1.req_ready, b1.cell_en} !== 2'b00) begin miscompares++; $display("FAIL bp%0d_ready_en got=%b%b want=00", i, b1.req_ready, b1.cell_en); end
      @(negedge clk);
    end
    vectors++; if (b1.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got=%b want=1", b1.rsp_valid); end
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({b1.req_ready, b1.rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL bp_release got=%b%b want=10", b1.req_ready, b1.rsp_valid); end
  endtask

  task automatic test_reset_midflight;
    logic early, v, seen;
    logic [31:0] d;
    b1.rsp_ready = 1'b1;
    issue1(OP_MULXSS, 32'h8000_0001, 32'h8000_0003);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (b1.req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready_gated got=%b want=0", b1.req_ready); end
    reset = 1'b0;
    #1;
    vectors++; if ({b1.req_ready, b1.cell_en} !== 2'b10) begin miscompares++; $display("FAIL rst_mid_after got=%b%b want=10", b1.req_ready, b1.cell_en); end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= b1.rsp_valid;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_rsp got=%b want=0", seen); end
    run1(OP_MUL, 32'd7, 32'd6, 3, early, v, d);
    vectors++; if ({v, d} !== {1'b1, 32'h0000_002A}) begin miscompares++; $display("FAIL rst_mid_next got=%b/%h want=1/0000002a", v, d); end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    b1.rsp_ready = 1'b0;
    issue1(OP_MUL, 32'h0000_1234, 32'h0000_0010);
    b1.req_valid = 1'b1;
    b1.req_op = OP_MULXSS;
    b1.req_a = 32'd5;
    b1.req_b = 32'd5;
    repeat (2) @(negedge clk);
    vectors++; if ({b1.rsp_valid, b1.rsp_data} !== {1'b1, 32'h0001_2340}) begin miscompares++; $display("FAIL ign_rsp got=%b/%h want=1/00012340", b1.rsp_valid, b1.rsp_data); end
    vectors++; if (b1.cell_src1 !== 32'h0000_1234) begin miscompares++; $display("FAIL ign_src1 got=%h want=00001234", b1.cell_src1); end
    @(negedge clk);
    vectors++; if (b1.rsp_data !== 32'h0001_2340) begin miscompares++; $display("FAIL ign_hold got=%h want=00012340", b1.rsp_data); end
    b1.req_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({b1.req_ready, b1.rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL ign_idle got=%b%b want=10", b1.req_ready, b1.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    logic early, v;
    logic [31:0] d;
    b1.rsp_ready = 1'b1;
    run1(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 3, early, v, d);
    vectors++; if ({early, v, d} !== {2'b01, 32'hFFFF_FFFE}) begin miscompares++; $display("FAIL b2b_first got=%b%b/%h want=01/fffffffe", early, v, d); end
    @(negedge clk);
    vectors++; if (b1.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got=%b want=1", b1.req_ready); end
    run1(OP_MUL, 32'h1234_5678, 32'h0000_0010, 3, early, v, d);
    vectors++; if ({early, v, d} !== {2'b01, 32'h2345_6780}) begin miscompares++; $display("FAIL b2b_second got=%b%b/%h want=01/23456780", early, v, d); end
    @(negedge clk);
  endtask

  task automatic test_latency3;
    logic early, v;
    logic [31:0] d;
    b3.rsp_ready = 1'b1;
    run3(OP_MUL, 32'h0001_0003, 32'h0002_0005, 5, early, v, d);
    vectors++; if ({early, v} !== 2'b01) begin miscompares++; $display("FAIL l3_mul_timing got=%b%b want=01", early, v); end
    vectors++; if (d !== 32'h000B_000F) begin miscompares++; $display("FAIL l3_mul_data got=%h want=000b000f", d); end
    @(negedge clk);
    run3(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, early, v, d);
    vectors++; if ({early, v} !== 2'b01) begin miscompares++; $display("FAIL l3_mulx_timing got=%b%b want=01", early, v); end
    vectors++; if (d !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL l3_mulx_data got=%h want=fffffffe", d); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    b1.req_valid = 1'b0; b1.req_op = 2'b00; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1'b0;
    b3.req_valid = 1'b0; b3.req_op = 2'b00; b3.req_a = '0; b3.req_b = '0; b3.rsp_ready = 1'b0;
    test_reset;
    test_mul;
    test_mulxuu;
    test_signed;
    test_backpressure;
    test_reset_midflight;
    test_ignore;
    test_back_to_back;
    test_latency3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
